gate_sweep_ctrl: RTL

//  Sequencer for exhaustive truth-table checking of a gate-level datapath
//  (e.g. two cascaded and_gate instances, inputs a/b/d -> out).
//  - On start, drives every input vector 0 .. 2^N_IN-1 onto the DUT inputs.
//  - Waits a settle window, then samples the DUT output.
//  - Compares the sample against a reference function chosen by op_sel.
//  - Reports pass/fail, the error count and the first failing vector.

---
 rtl/gate_sweep_ctrl_pkg.sv | 23 ++
 rtl/gate_sweep_ctrl_if.sv | 48 ++++
 rtl/gate_sweep_ctrl_ref_model.sv | 23 ++
 rtl/gate_sweep_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared types for the gate-network truth-table sweeper.
// Holds the FSM state encoding and the reference-function selector.
package gate_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } sweep_state_t;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } gate_op_t;

   localparam int N_IN_MIN = 1;
   localparam int N_IN_MAX = 8;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Bus between the sweep controller and its user / gate network under test.
// start is a level sampled only while the controller is IDLE (no ready back);
// done is a single-cycle completion pulse, results stay stable until next start.
interface gate_sweep_ctrl_if #(
   parameter int N_IN = 3
) ();

   logic                          start;
   logic [1:0]                    op_sel;
   logic [N_IN-1:0]               dut_in;
   logic                          dut_out;
   logic                          busy;
   logic                          done;
   logic                          pass;
   logic [N_IN:0]                 err_cnt;
   logic [N_IN-1:0]               first_fail_vec;
   logic                          first_fail_vld;
   gate_sweep_pkg::sweep_state_t  state_dbg;

   modport master (
      output start,
      output op_sel,
      output dut_out,
      input  dut_in,
      input  busy,
      input  done,
      input  pass,
      input  err_cnt,
      input  first_fail_vec,
      input  first_fail_vld,
      input  state_dbg
   );

   modport slave (
      input  start,
      input  op_sel,
      input  dut_out,
      output dut_in,
      output busy,
      output done,
      output pass,
      output err_cnt,
      output first_fail_vec,
      output first_fail_vld,
      output state_dbg
   );

endinterface

// File: rtl/gate_sweep_ctrl_ref_model.sv
// Combinational golden model: reduction of the applied vector by the selected op.
module gate_ref_model
   import gate_sweep_pkg::*;
#(
   parameter int N_IN = 3
) (
   input  gate_op_t         i_op,
   input  logic [N_IN-1:0]  i_vec,
   output logic             o_ref
);

   always_comb begin
      o_ref = 1'b0;
      case (i_op)
         OP_AND:  o_ref = &i_vec;
         OP_OR:   o_ref = |i_vec;
         OP_XOR:  o_ref = ^i_vec;
         OP_NAND: o_ref = ~(&i_vec);
         default: o_ref = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweeper: drives every input vector, waits a settle
// window, samples the network output and tallies mismatches against a reference.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int N_IN       = 3,
   parameter int SETTLE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   gate_sweep_ctrl_if.slave  bus
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   // vec carries one extra bit so the terminal compare never wraps
   localparam logic [N_IN:0] LAST_VEC = (N_IN+1)'((1 << N_IN) - 1);
   localparam logic [N_IN:0] ONE_V    = (N_IN+1)'(1);
   localparam logic [SW-1:0] SET_LOAD = SW'(SETTLE_CYC - 1);
   localparam logic [SW-1:0] ONE_S    = SW'(1);

   sweep_state_t     r_state;
   gate_op_t         r_op;
   logic [N_IN:0]    r_vec;
   logic [SW-1:0]    r_settle;
   logic [N_IN-1:0]  r_dut_in;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [N_IN:0]    r_err_cnt;
   logic [N_IN-1:0]  r_ff_vec;
   logic             r_ff_vld;

   logic             w_ref;
   logic             w_mismatch;
   logic             w_last;
   logic [N_IN:0]    w_vec_nxt;

   gate_ref_model #(
      .N_IN (N_IN)
   ) u_ref (
      .i_op  (r_op),
      .i_vec (r_vec[N_IN-1:0]),
      .o_ref (w_ref)
   );

   assign w_mismatch = (bus.dut_out != w_ref);
   assign w_last     = (r_vec == LAST_VEC);
   assign w_vec_nxt  = r_vec + ONE_V;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= OP_AND;
         r_vec     <= '0;
         r_settle  <= '0;
         r_dut_in  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_err_cnt <= '0;
         r_ff_vec  <= '0;
         r_ff_vld  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_op      <= gate_op_t'(bus.op_sel);
                  r_vec     <= '0;
                  r_dut_in  <= '0;
                  r_err_cnt <= '0;
                  r_pass    <= 1'b0;
                  r_ff_vec  <= '0;
                  r_ff_vld  <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= DRIVE;
               end
            end
            DRIVE: begin
               r_settle <= SET_LOAD;
               r_state  <= SETTLE;
            end
            SETTLE: begin
               if (r_settle == '0) begin
                  r_state <= SAMPLE;
               end else begin
                  r_settle <= r_settle - ONE_S;
               end
            end
            SAMPLE: begin
               if (w_mismatch) begin
                  r_err_cnt <= r_err_cnt + ONE_V;
                  if (!r_ff_vld) begin
                     r_ff_vec <= r_vec[N_IN-1:0];
                     r_ff_vld <= 1'b1;
                  end
               end
               if (w_last) begin
                  // dut_in returns to 0 as the DONE cycle begins
                  r_dut_in <= '0;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_pass   <= (r_err_cnt == '0) && !w_mismatch;
                  r_state  <= DONE;
               end else begin
                  r_vec    <= w_vec_nxt;
                  r_dut_in <= w_vec_nxt[N_IN-1:0];
                  r_state  <= DRIVE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.dut_in         = r_dut_in;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.pass           = r_pass;
   assign bus.err_cnt        = r_err_cnt;
   assign bus.first_fail_vec = r_ff_vec;
   assign bus.first_fail_vld = r_ff_vld;
   assign bus.state_dbg      = r_state;

endmodule
